uart_ctrl: RTL
==============

UART_CTRL -- requirements
Module: uart_ctrl

Interface
REQ-001 Parameter DEPTH, default 8, meaning entries per FIFO (TX and RX); SHALL be a power of two, 2..64.
REQ-002 clock  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 resetn  in  1  reset, asynchronous, active-low.
REQ-004 uart_en  in  1  enable; when low, no new transmission SHALL start.
REQ-005 wr_en  in  1  push wr_data into TX FIFO.
REQ-006 wr_data  in  8  TX byte.
REQ-007 tx_flush  in  1  synchronous clear of TX FIFO contents.
REQ-008 tx_full / tx_empty  out  1 each  TX FIFO status.
REQ-009 tx_level  out  log2(DEPTH)+1  TX FIFO occupancy.
REQ-010 wr_ovf  out  1  one-cycle pulse: push rejected.
REQ-011 rd_en  in  1  pop RX FIFO head.
REQ-012 rd_data  out  8  RX FIFO head (show-ahead), valid while !rx_empty.
REQ-013 rx_full / rx_empty  out  1 each; rx_level  out  log2(DEPTH)+1.
REQ-014 rx_overflow  out  1  sticky: received byte dropped.
REQ-015 clr_ovf  in  1  clears rx_overflow.
REQ-016 busy  out  1  high in any state other than IDLE.
REQ-017 start_tx  out  1  one-cycle transmit strobe to UART core.
REQ-018 tx_byte  out  8  byte to UART core data_in; held stable from start_tx until tx_done.
REQ-019 tx_done  in  1  one-cycle pulse from UART core at end of stop bit.
REQ-020 rec_valid  in  1  one-cycle pulse from UART core; rec_dat valid that cycle.
REQ-021 rec_dat  in  8  received byte.

Function
REQ-022 TX FSM states IDLE, SEND, WAIT, registered.
REQ-023 IDLE: if uart_en and !tx_empty, pop TX head into tx_byte and go to SEND; else stay.
REQ-024 SEND: start_tx=1 for exactly this cycle; go to WAIT unconditionally; tx_done in SEND SHALL be ignored.
REQ-025 WAIT: on tx_done go to IDLE; next byte (if any) SHALL start with start_tx two cycles after tx_done.
REQ-026 Latency: wr_en in cycle N into empty FIFO with FSM idle and uart_en high -> start_tx high in cycle N+2.
REQ-027 uart_en low in SEND or WAIT -> IDLE next cycle, start_tx low, in-flight byte discarded, FIFO contents retained.
REQ-028 wr_en with tx_full -> byte discarded, wr_ovf=1 next cycle, even if the FSM pops in the same cycle.
REQ-029 tx_flush -> TX FIFO empty next cycle; overrides a simultaneous wr_en; an in-flight byte completes normally.
REQ-030 rec_valid with !rx_full, or with rx_full and rd_en the same cycle -> byte pushed (level unchanged in the latter case).
REQ-031 rec_valid with rx_full and !rd_en -> byte dropped, rx_overflow=1 next cycle, held until clr_ovf; clr_ovf with simultaneous drop leaves it set.
REQ-032 rd_en with rx_empty SHALL be ignored; rd_en and push on empty SHALL leave level 1, new byte at head.
REQ-033 FIFO pointers SHALL wrap modulo DEPTH; level = 0..DEPTH; full = (level==DEPTH), empty = (level==0).
REQ-034 RX capture SHALL be independent of uart_en and TX FSM state.

Reset
REQ-035 resetn low SHALL immediately force FSM=IDLE, both FIFOs empty, start_tx=0, tx_byte=0x00, wr_ovf=0, rx_overflow=0, busy=0, levels=0, tx_empty=rx_empty=1, full flags 0, rd_data=0x00.
REQ-036 Reset mid-transmission SHALL abort without emitting start_tx after release; first start_tx only after a new wr_en.

Verification
REQ-037 Push 0xA5 at cycle 10, uart_en=1 -> start_tx in cycle 12 with tx_byte=0xA5, busy 12..tx_done+1.
REQ-038 Push 0x01,0x02,0x03; tx_done 20 cycles after each start_tx -> three start_tx in order, each 2 cycles after the prior tx_done, tx_empty=1 after third pop.
REQ-039 Fill TX with DEPTH=8 bytes while uart_en=0, push 9th -> tx_full=1, tx_level=8, wr_ovf pulse; ninth byte never transmitted.
REQ-040 Nine rec_valid pulses (0x10..0x18) with no reads -> rx_full=1, rx_overflow=1, reads return 0x10..0x17; clr_ovf -> rx_overflow=0.
REQ-041 rec_valid with rx_full and rd_en same cycle -> no overflow, rx_level stays 8, new byte last out.
REQ-042 Drop uart_en in WAIT, and separately assert resetn=0 in WAIT -> IDLE next cycle / immediately, no further start_tx until re-enabled or new data.

Source files
------------

// File: rtl/uart_ctrl.sv
// uart_ctrl: byte-level controller sitting between a host and a UART core.
//
// A TX FIFO collects host bytes. A three-state FSM (IDLE/SEND/WAIT) hands
// them one at a time to the core: it strobes start_tx and holds tx_byte
// until the core reports tx_done. An RX FIFO captures bytes the core
// delivers on rec_valid. The RX FIFO is read show-ahead style.
//
// Ports
//   clock, resetn        sole clock, asynchronous active-low reset
//   uart_en              gate for starting new transmissions
//   wr_en, wr_data       push into TX FIFO
//   tx_flush             synchronous clear of TX FIFO
//   tx_full, tx_empty    TX FIFO status
//   tx_level             TX FIFO occupancy
//   wr_ovf               one-cycle pulse when a push is rejected
//   rd_en, rd_data       pop / show-ahead head of RX FIFO
//   rx_full, rx_empty    RX FIFO status
//   rx_level             RX FIFO occupancy
//   rx_overflow          sticky flag for a dropped received byte
//   clr_ovf              clears rx_overflow
//   busy                 FSM not idle
//   start_tx, tx_byte    strobe and data to the UART core
//   tx_done              end-of-frame pulse from the UART core
//   rec_valid, rec_dat   received byte from the UART core
module uart_ctrl #(
    parameter int DEPTH = 8
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   uart_en,
    input  logic                   wr_en,
    input  logic [7:0]             wr_data,
    input  logic                   tx_flush,
    output logic                   tx_full,
    output logic                   tx_empty,
    output logic [$clog2(DEPTH):0] tx_level,
    output logic                   wr_ovf,
    input  logic                   rd_en,
    output logic [7:0]             rd_data,
    output logic                   rx_full,
    output logic                   rx_empty,
    output logic [$clog2(DEPTH):0] rx_level,
    output logic                   rx_overflow,
    input  logic                   clr_ovf,
    output logic                   busy,
    output logic                   start_tx,
    output logic [7:0]             tx_byte,
    input  logic                   tx_done,
    input  logic                   rec_valid,
    input  logic [7:0]             rec_dat
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef logic [AW-1:0] ptr_t;
    typedef logic [LW-1:0] lvl_t;

    localparam lvl_t FULL_LVL = lvl_t'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT
    } state_t;

    state_t     state;

    logic [7:0] tx_mem [DEPTH];
    ptr_t       tx_wr_ptr;
    ptr_t       tx_rd_ptr;
    logic       tx_push;
    logic       tx_pop;

    logic [7:0] rx_mem [DEPTH];
    ptr_t       rx_wr_ptr;
    ptr_t       rx_rd_ptr;
    logic       rx_push;
    logic       rx_pop;
    logic       rx_drop;

    assign tx_full  = (tx_level == FULL_LVL);
    assign tx_empty = (tx_level == '0);
    assign rx_full  = (rx_level == FULL_LVL);
    assign rx_empty = (rx_level == '0);

    // A full FIFO rejects a push even when the FSM pops in the same cycle;
    // a flush discards any push made alongside it.
    assign tx_push = wr_en && !tx_full && !tx_flush;
    assign tx_pop  = (state == ST_IDLE) && uart_en && !tx_empty;

    // A read on a full FIFO frees the slot the incoming byte lands in.
    assign rx_pop  = rd_en && !rx_empty;
    assign rx_push = rec_valid && (!rx_full || rd_en);
    assign rx_drop = rec_valid && rx_full && !rd_en;

    // Head is forced to zero while empty so the output is defined after reset.
    assign rd_data = rx_empty ? 8'h00 : rx_mem[rx_rd_ptr];

    // TX FIFO storage
    always_ff @(posedge clock) begin
        if (tx_push) begin
            tx_mem[tx_wr_ptr] <= wr_data;
        end
    end

    // TX FIFO pointers, occupancy and overflow pulse
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_level  <= '0;
            wr_ovf    <= 1'b0;
        end else begin
            wr_ovf <= wr_en && tx_full;
            if (tx_flush) begin
                tx_wr_ptr <= '0;
                tx_rd_ptr <= '0;
                tx_level  <= '0;
            end else begin
                if (tx_push) tx_wr_ptr <= tx_wr_ptr + ptr_t'(1);
                if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + ptr_t'(1);
                case ({tx_push, tx_pop})
                    2'b10:   tx_level <= tx_level + lvl_t'(1);
                    2'b01:   tx_level <= tx_level - lvl_t'(1);
                    default: tx_level <= tx_level;
                endcase
            end
        end
    end

    // RX FIFO storage
    always_ff @(posedge clock) begin
        if (rx_push) begin
            rx_mem[rx_wr_ptr] <= rec_dat;
        end
    end

    // RX FIFO pointers, occupancy and sticky overflow
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rx_wr_ptr   <= '0;
            rx_rd_ptr   <= '0;
            rx_level    <= '0;
            rx_overflow <= 1'b0;
        end else begin
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + ptr_t'(1);
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + ptr_t'(1);
            case ({rx_push, rx_pop})
                2'b10:   rx_level <= rx_level + lvl_t'(1);
                2'b01:   rx_level <= rx_level - lvl_t'(1);
                default: rx_level <= rx_level;
            endcase
            // A drop in the same cycle as clr_ovf wins.
            if (rx_drop) begin
                rx_overflow <= 1'b1;
            end else if (clr_ovf) begin
                rx_overflow <= 1'b0;
            end
        end
    end

    // TX FSM with registered start_tx, busy and tx_byte
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state    <= ST_IDLE;
            start_tx <= 1'b0;
            busy     <= 1'b0;
            tx_byte  <= 8'h00;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (tx_pop) begin
                        tx_byte  <= tx_mem[tx_rd_ptr];
                        state    <= ST_SEND;
                        start_tx <= 1'b1;
                        busy     <= 1'b1;
                    end else begin
                        start_tx <= 1'b0;
                        busy     <= 1'b0;
                    end
                end
                ST_SEND: begin
                    // tx_done here belongs to no frame of ours and is ignored.
                    start_tx <= 1'b0;
                    if (!uart_en) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    start_tx <= 1'b0;
                    if (!uart_en || tx_done) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    start_tx <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule
